// File: rtl/ext_pipe.sv
// rtl/ext_pipe.sv - elastic immediate-extension pipeline with per-stage valid bits
module ext_pipe #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [1:0]                   ExtOp,
    input  logic [IN_W-1:0]              data_in,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [OUT_W-1:0]             data_out,
    output logic [$clog2(DEPTH+1)-1:0]   occ
);

    localparam int OCC_W = $clog2(DEPTH+1);

    logic [DEPTH-1:0] v;
    logic [OUT_W-1:0] d [DEPTH];
    logic [DEPTH-1:0] rdy;
    logic             chain;
    logic [OUT_W-1:0] sext;
    logic [OUT_W-1:0] ext;

    // Extension of the incoming immediate; branch offsets drop the top two sign bits via the shift
    always_comb begin
        sext = {{(OUT_W-IN_W){data_in[IN_W-1]}}, data_in};
        ext  = '0;
        case (ExtOp)
            2'b00:   ext = {{(OUT_W-IN_W){1'b0}}, data_in};
            2'b01:   ext = sext;
            2'b10:   ext = {data_in, {(OUT_W-IN_W){1'b0}}};
            default: ext = sext << 2;
        endcase
    end

    // A stage may load when it or any stage downstream of it is empty, or the sink is draining
    always_comb begin
        rdy   = '0;
        chain = out_ready;
        for (int k = DEPTH-1; k >= 0; k--) begin
            chain  = chain | ~v[k];
            rdy[k] = chain;
        end
    end

    assign in_ready  = rst_n & rdy[0];
    assign out_valid = v[DEPTH-1];
    assign data_out  = d[DEPTH-1];

    // Stage registers: capture into stage 0, shift forward where the next stage can take it
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                d[k] <= '0;
            end
        end else begin
            if (rdy[0]) begin
                v[0] <= in_valid;
                if (in_valid) begin
                    d[0] <= ext;
                end
            end
            for (int k = 1; k < DEPTH; k++) begin
                if (rdy[k]) begin
                    v[k] <= v[k-1];
                    if (v[k-1]) begin
                        d[k] <= d[k-1];
                    end
                end
            end
        end
    end

    // Occupancy is the population count of the valid bits
    always_comb begin
        occ = '0;
        for (int k = 0; k < DEPTH; k++) begin
            occ = occ + OCC_W'(v[k]);
        end
    end

endmodule

// File: tb/tb_ext_pipe.sv
// tb/tb_ext_pipe.sv - randomized and directed bench for ext_pipe at DEPTH 2, 1 and 4
module tb_ext_pipe;

    localparam int NI = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [1:0]  ext_op = 2'b00;
    logic [15:0] data16 = 16'h0000;
    logic [11:0] data12;

    logic        inr2, inr1, inr4;
    logic        ov2, ov1, ov4;
    logic [31:0] do2, do1, do4;
    logic [1:0]  occ2;
    logic [0:0]  occ1;
    logic [2:0]  occ4;

    int          checks = 0;
    int          passes = 0;
    bit          started = 0;

    logic        d_inr  [NI];
    logic        d_ov   [NI];
    logic [31:0] d_data [NI];
    int          d_occ  [NI];

    logic [31:0] m_data [NI][4];
    int          m_pos  [NI][4];
    int          m_cnt  [NI];
    bit          m_zero [NI];
    int          acc_cnt[NI];

    assign data12 = data16[11:0];

    ext_pipe #(.IN_W(16), .OUT_W(32), .DEPTH(2)) u_d2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(inr2), .ExtOp(ext_op),
        .data_in(data16), .out_valid(ov2), .out_ready(out_ready), .data_out(do2), .occ(occ2));
    ext_pipe #(.IN_W(12), .OUT_W(32), .DEPTH(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(inr1), .ExtOp(ext_op),
        .data_in(data12), .out_valid(ov1), .out_ready(out_ready), .data_out(do1), .occ(occ1));
    ext_pipe #(.IN_W(12), .OUT_W(32), .DEPTH(4)) u_d4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(inr4), .ExtOp(ext_op),
        .data_in(data12), .out_valid(ov4), .out_ready(out_ready), .data_out(do4), .occ(occ4));

    always #5 clk = ~clk;

    always_comb begin
        d_inr[0] = inr2;  d_ov[0] = ov2;  d_data[0] = do2;  d_occ[0] = int'(occ2);
        d_inr[1] = inr1;  d_ov[1] = ov1;  d_data[1] = do1;  d_occ[1] = int'(occ1);
        d_inr[2] = inr4;  d_ov[2] = ov4;  d_data[2] = do4;  d_occ[2] = int'(occ4);
    end

    function automatic int dep(int i);
        return (i == 0) ? 2 : (i == 1) ? 1 : 4;
    endfunction

    function automatic int inw(int i);
        return (i == 0) ? 16 : 12;
    endfunction

    function automatic logic [31:0] ext_model(int mode, int unsigned raw, int w);
        longint u, s;
        u = longint'(raw) & ((longint'(1) << w) - 1);
        s = (u >= (longint'(1) << (w-1))) ? u - (longint'(1) << w) : u;
        case (mode)
            0:       return u[31:0];
            1:       return s[31:0];
            2:       return 32'(u << (32 - w));
            default: return 32'(s * 4);
        endcase
    endfunction

    task automatic chk(string nm, int i, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s inst%0d: got %0h, want %0h", nm, i, act, exp);
    endtask

    // Each queued item ages one slot per cycle toward the output but never passes the items ahead of it
    task automatic model_step(int i);
        int  dd;
        bit  inr, pop;
        dd = dep(i);
        if (!rst_n) begin
            m_cnt[i]  = 0;
            m_zero[i] = 1;
            return;
        end
        inr = out_ready || (m_cnt[i] < dd);
        pop = (m_cnt[i] > 0) && (m_pos[i][0] == dd-1) && out_ready;
        if (pop) begin
            for (int j = 0; j < m_cnt[i]-1; j++) begin
                m_data[i][j] = m_data[i][j+1];
                m_pos[i][j]  = m_pos[i][j+1];
            end
            m_cnt[i]--;
        end
        for (int j = 0; j < m_cnt[i]; j++) begin
            m_pos[i][j] = (m_pos[i][j]+1 < dd-1-j) ? m_pos[i][j]+1 : dd-1-j;
            if (m_pos[i][j] == dd-1) m_zero[i] = 0;
        end
        if (in_valid && inr) begin
            m_data[i][m_cnt[i]] = ext_model(int'(ext_op), (i == 0) ? int'(data16) : int'(data12), inw(i));
            m_pos[i][m_cnt[i]]  = 0;
            if (dd == 1) m_zero[i] = 0;
            m_cnt[i]++;
            acc_cnt[i]++;
        end
    endtask

    // Compare every instance against the model, then advance the model over the coming edge
    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (started) begin
                bit exp_ov;
                exp_ov = (m_cnt[i] > 0) && (m_pos[i][0] == dep(i)-1);
                chk("in_ready", i, d_inr[i], rst_n && (out_ready || m_cnt[i] < dep(i)));
                chk("out_valid", i, d_ov[i], exp_ov);
                chk("occ", i, d_occ[i], m_cnt[i]);
                if (exp_ov) chk("data_out", i, d_data[i], m_data[i][0]);
                else if (m_zero[i]) chk("data_out_zero", i, d_data[i], 0);
            end
            model_step(i);
        end
        if (!rst_n) started = 1;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_item(int mode, logic [15:0] d);
        in_valid = 1'b1;
        ext_op   = 2'(mode);
        data16   = d;
    endtask

    task automatic measure(logic [31:0] e16, logic [31:0] e12);
        int lat[NI];
        int nv[NI];
        cyc();
        in_valid = 1'b0;
        data16   = 16'($urandom);
        ext_op   = 2'($urandom);
        for (int i = 0; i < NI; i++) begin
            lat[i] = 0;
            nv[i]  = 0;
        end
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                if (d_ov[i]) begin
                    nv[i]++;
                    if (lat[i] == 0) begin
                        lat[i] = c;
                        chk("lit_data", i, d_data[i], (i == 0) ? e16 : e12);
                    end
                end
            end
        end
        for (int i = 0; i < NI; i++) begin
            chk("latency", i, lat[i], dep(i));
            chk("valid_cycles", i, nv[i], 1);
        end
    endtask

    task automatic single(int mode, logic [15:0] d, logic [31:0] e16, logic [31:0] e12);
        cyc();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (5) cyc();
        drive_item(mode, d);
        measure(e16, e12);
    endtask

    initial begin
        int a2;
        for (int i = 0; i < NI; i++) acc_cnt[i] = 0;
        chk("model_sext12", 1, ext_model(1, 'h800, 12), 32'hFFFFF800);
        chk("model_branch", 0, ext_model(3, 'h7FFF, 16), 32'h0001FFFC);
        chk("model_upper", 0, ext_model(2, 'hABCD, 16), 32'hABCD0000);
        repeat (3) cyc();
        rst_n = 1'b1;

        single(0, 16'hFFFF, 32'h0000FFFF, 32'h00000FFF);
        single(1, 16'hFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
        single(2, 16'hFFFF, 32'hFFFF0000, 32'hFFF00000);
        single(3, 16'hFFFF, 32'hFFFFFFFC, 32'hFFFFFFFC);
        single(1, 16'h7FFF, 32'h00007FFF, 32'hFFFFFFFF);
        single(3, 16'h7FFF, 32'h0001FFFC, 32'hFFFFFFFC);
        single(3, 16'h8000, 32'hFFFE0000, 32'h00000000);
        single(1, 16'h0800, 32'h00000800, 32'hFFFFF800);

        cyc();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (6) cyc();
        a2 = acc_cnt[0];
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive_item(1, 16'h1000 + 16'(k));
            cyc();
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp_accepts", 0, acc_cnt[0] - a2, 2);
        chk("bp_occ", 0, d_occ[0], 2);
        chk("bp_occ", 1, d_occ[1], 1);
        chk("bp_occ", 2, d_occ[2], 4);
        chk("bp_in_ready", 0, d_inr[0], 0);
        repeat (3) begin
            cyc();
            @(negedge clk);
            chk("bp_hold", 0, d_data[0], 32'h00001000);
        end
        cyc();
        out_ready = 1'b1;
        cyc();
        @(negedge clk);
        chk("bp_next", 0, d_data[0], 32'h00001001);

        cyc();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        repeat (5) begin
            data16 = 16'($urandom);
            cyc();
        end
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            ext_op = 2'($urandom);
            data16 = 16'($urandom);
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                chk("pt_occ", i, d_occ[i], dep(i));
                chk("pt_in_ready", i, d_inr[i], 1);
            end
            cyc();
        end

        out_ready = 1'b0;
        in_valid  = 1'b1;
        repeat (3) cyc();
        @(negedge clk);
        chk("rst_pre_occ", 0, d_occ[0], 2);
        cyc();
        rst_n = 1'b0;
        cyc();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        drive_item(3, 16'h8000);
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            chk("rst_occ", i, d_occ[i], 0);
            chk("rst_out_valid", i, d_ov[i], 0);
            chk("rst_data", i, d_data[i], 0);
        end
        measure(32'hFFFE0000, 32'h00000000);

        for (int n = 0; n < 3000; n++) begin
            rst_n     = ($urandom_range(0, 299) != 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = (n % 200 < 40) ? 1'b0 : ($urandom_range(0, 2) != 0);
            ext_op    = 2'($urandom);
            data16    = 16'($urandom);
            cyc();
        end
        rst_n = 1'b1;
        in_valid = 1'b0;
        repeat (2) cyc();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/ext_pipe.md
EXT_PIPE -- requirements
Module: ext_pipe

Interface
Parameters:
REQ-001 The block SHALL have parameter IN_W, default 16, meaning immediate input width.
REQ-002 The block SHALL have parameter OUT_W, default 32, meaning extended output width; legal range OUT_W >= IN_W+2.
REQ-003 The block SHALL have parameter DEPTH, default 2, meaning number of register stages; legal range 1..4.

Ports:
REQ-004 The block SHALL have port clk  input  1  rising-edge clock, the only clock.
REQ-005 The block SHALL have port rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-006 The block SHALL have port in_valid  input  1  upstream data valid.
REQ-007 The block SHALL have port in_ready  output  1  block can accept this cycle.
REQ-008 The block SHALL have port ExtOp  input  2  mode: 00 zero-ext, 01 sign-ext, 10 upper-load, 11 branch-offset.
REQ-009 The block SHALL have port data_in  input  IN_W  immediate field.
REQ-010 The block SHALL have port out_valid  output  1  result valid.
REQ-011 The block SHALL have port out_ready  input  1  downstream accepts.
REQ-012 The block SHALL have port data_out  output  OUT_W  extended result.
REQ-013 The block SHALL have port occ  output  $clog2(DEPTH+1)  number of stages holding valid data.

Function
REQ-014 A transfer in SHALL occur on a clk edge where in_valid=1 and in_ready=1; a transfer out SHALL occur where out_valid=1 and out_ready=1.
REQ-015 The computation in each mode SHALL be:
- Mode 00: data_out SHALL be {zeros, data_in}.
- Mode 01: data_out SHALL be data_in replicated from bit IN_W-1 to OUT_W bits.
- Mode 10: data_out SHALL be data_in << (OUT_W-IN_W), with the low bits zero.
- Mode 11: data_out SHALL be (sign-extended data_in) << 2, with bits [1:0]=0 and the upper two sign bits discarded.
REQ-016 The extension result SHALL be computed from data_in and ExtOp at the input transfer and captured into stage 0; later stages SHALL carry it unchanged.
REQ-017 The pipeline SHALL be elastic with per-stage valid bits v[0..DEPTH-1].
- Stage k ready SHALL equal !v[k] | ready(k+1).
- ready(DEPTH) SHALL equal out_ready.
- in_ready SHALL equal ready(0).
REQ-018 out_valid SHALL equal v[DEPTH-1], and data_out SHALL equal that stage's data register.
REQ-019 Latency SHALL be exactly DEPTH cycles: an input accepted at edge N SHALL be presented with out_valid=1 after edge N+DEPTH-1, for transfer-out at edge N+DEPTH, when out_ready stays 1.
REQ-020 Throughput SHALL be one transfer per cycle when out_ready=1 continuously; no bubbles SHALL be inserted.
REQ-021 When out_ready=0, data_out and out_valid SHALL hold stable until a transfer out occurs.
REQ-022 Bubbles SHALL collapse: when out_ready=0, upstream stages SHALL keep accepting until all DEPTH stages are valid (occ=DEPTH).
REQ-023 When full (occ=DEPTH) with out_ready=0, in_ready SHALL be 0 and no data SHALL be lost or overwritten.
REQ-024 When full with out_ready=1, in_ready SHALL be 1, and a simultaneous transfer in and out SHALL leave occ at DEPTH.
REQ-025 occ SHALL change by +1 on a transfer in alone, -1 on a transfer out alone, and 0 on both or neither.
REQ-026 Items SHALL leave in strict arrival order, with no reordering or duplication.
REQ-027 in_valid=1 with in_ready=0 SHALL have no effect, and upstream SHALL be allowed to change data_in freely while in_valid=0.

Reset
REQ-028 When rst_n=0 at a clk edge, all v[k] SHALL be 0, all data registers SHALL be 0, occ SHALL be 0, out_valid SHALL be 0, and data_out SHALL be 0.
REQ-029 While rst_n=0, in_ready SHALL be 0, and no transfer in SHALL be recorded.
REQ-030 Reset asserted mid-operation SHALL discard all in-flight items at that edge.
REQ-031 On the first edge after rst_n returns to 1, the block SHALL accept input normally.

Verification
REQ-032 The bench SHALL cover mode sweep at DEPTH=2, out_ready=1: inputs FFFF in each of modes 00/01/10/11 -> outputs 0000FFFF, FFFFFFFF, FFFF0000, FFFFFFFC, each 2 cycles after accept.
REQ-033 The bench SHALL cover positive sign case: data_in=7FFF, mode 01 -> 00007FFF; mode 11 -> 0001FFFC; data_in=8000, mode 11 -> FFFE0000.
REQ-034 The bench SHALL cover backpressure: out_ready=0 with 4 back-to-back inputs at DEPTH=2 -> in_ready drops after 2 accepts, occ=2, data_out stable; then out_ready=1 -> remaining items delivered in order with no loss.
REQ-035 The bench SHALL cover full pass-through: occ=DEPTH, in_valid=1, out_ready=1 continuously -> one out and one in per cycle, occ constant.
REQ-036 The bench SHALL cover reset mid-stream: rst_n=0 for one edge with occ=2 -> occ=0, out_valid=0, data_out=0; the next item after release emerges alone with DEPTH-cycle latency.
REQ-037 The bench SHALL cover parameter corners: DEPTH=1 and DEPTH=4, IN_W=12, OUT_W=32 -> latency equals DEPTH, and mode 01 on 800 gives FFFFF800.
